// File: rtl/event_enc_pkg.sv
// Shared definitions for the 8-to-3 event encoder.
//   state_e   : two-state offer FSM encoding
//   N_IN      : number of event lines
//   W_CODE    : width of the binary event index
//   W_CNT     : width of the pending population count (0..N_IN)
//   onehot()  : index -> one-hot mask over N_IN bits
//   popcount(): number of set bits in an N_IN-bit vector
package event_enc_pkg;

    localparam int N_IN   = 8;
    localparam int W_CODE = 3;
    localparam int W_CNT  = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_e;

    function automatic logic [N_IN-1:0] onehot(input logic [W_CODE-1:0] idx);
        logic [N_IN-1:0] mask;
        mask      = '0;
        mask[idx] = 1'b1;
        return mask;
    endfunction

    function automatic logic [W_CNT-1:0] popcount(input logic [N_IN-1:0] vec);
        logic [W_CNT-1:0] acc;
        acc = '0;
        for (int i = 0; i < N_IN; i++) begin
            acc = acc + W_CNT'(vec[i]);
        end
        return acc;
    endfunction

endpackage

// File: rtl/prio_enc_8x3.sv
// Combinational 8-to-3 priority encoder.
//   in_i   [7:0] : request vector (never all-zero when the result is used)
//   code_o [2:0] : index of the winning bit
// LOW_FIRST=1 picks the lowest set index, LOW_FIRST=0 the highest.
// An all-zero input yields 0; callers never rely on that value.
module prio_enc_8x3
    import event_enc_pkg::*;
#(
    parameter bit LOW_FIRST = 1'b1
) (
    input  logic [N_IN-1:0]   in_i,
    output logic [W_CODE-1:0] code_o
);

    // Scan toward the winning end; the last hit in the loop is the winner.
    always_comb begin
        code_o = '0;
        if (LOW_FIRST) begin
            for (int i = N_IN - 1; i >= 0; i--) begin
                if (in_i[i]) code_o = W_CODE'(i);
            end
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                if (in_i[i]) code_o = W_CODE'(i);
            end
        end
    end

endmodule

// File: rtl/event_encoder_8x3.sv
// Pending-event collector with a one-code-per-cycle priority offer port.
//   clk       : clock, all state on rising edge
//   rst       : synchronous active-high reset
//   req[7:0]  : event lines, each high bit sets its pending bit
//   ready     : consumer accepts the offered code this cycle
//   y[2:0]    : offered event index (0 when nothing is offered)
//   valid     : y holds a pending event index
//   pend[7:0] : registered pending vector
//   cnt[3:0]  : popcount of pend
//   ovf       : sticky overflow, set when an event hits an already-pending bit
//   dbg_state : FSM state (0 = idle, 1 = offering)
//
// Handshake: a code transfers on every rising edge where valid && ready are
// both high; while valid is high and ready is low, y is held stable.
module event_encoder_8x3
    import event_enc_pkg::*;
#(
    parameter bit LOW_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_IN-1:0]   req,
    input  logic              ready,
    output logic [W_CODE-1:0] y,
    output logic              valid,
    output logic [N_IN-1:0]   pend,
    output logic [W_CNT-1:0]  cnt,
    output logic              ovf,
    output logic              dbg_state
);

    state_e              state_q, state_d;
    logic [N_IN-1:0]     pend_q, pend_d;
    logic [W_CODE-1:0]   cur_q, cur_d;
    logic                ovf_q, ovf_d;

    logic                accept;
    logic [N_IN-1:0]     cur_mask;
    logic [N_IN-1:0]     clr;
    logic [N_IN-1:0]     remain;
    logic [W_CODE-1:0]   prio_pend;
    logic [W_CODE-1:0]   prio_remain;

    // One encoder picks the first offer from idle, the other picks the
    // follow-up offer from what remains after the current accept.
    prio_enc_8x3 #(.LOW_FIRST(LOW_FIRST)) u_prio_pend (
        .in_i   (pend_q),
        .code_o (prio_pend)
    );

    prio_enc_8x3 #(.LOW_FIRST(LOW_FIRST)) u_prio_remain (
        .in_i   (remain),
        .code_o (prio_remain)
    );

    // Pending vector and overflow. A req on the bit being cleared this edge
    // re-arms it and is not an overflow.
    always_comb begin
        accept   = (state_q == ST_OFFER) && ready;
        cur_mask = onehot(cur_q);
        clr      = accept ? cur_mask : '0;
        remain   = pend_q & ~cur_mask;
        pend_d   = (pend_q & ~clr) | req;
        ovf_d    = ovf_q | (|(req & pend_q & ~clr));
    end

    // Offer FSM. Decisions use the registered pend only, so a req arriving
    // during the final accept is offered through ST_IDLE one cycle later.
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        case (state_q)
            ST_IDLE: begin
                if (|pend_q) begin
                    cur_d   = prio_pend;
                    state_d = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (ready) begin
                    if (|remain) begin
                        cur_d = prio_remain;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
            cur_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            cur_q   <= cur_d;
            ovf_q   <= ovf_d;
        end
    end

    assign valid     = (state_q == ST_OFFER);
    assign y         = valid ? cur_q : '0;
    assign pend      = pend_q;
    assign cnt       = popcount(pend_q);
    assign ovf       = ovf_q;
    assign dbg_state = (state_q == ST_OFFER);

endmodule

// File: tb/tb_event_encoder_8x3.sv
// Bench for event_encoder_8x3: two instances (LOW_FIRST=1 and 0) share the
// same stimulus; each is checked every cycle against a behavioural model,
// and directed scenarios add literal expectations.
module tb_event_encoder_8x3;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       ready;

    logic [2:0] y_w     [2];
    logic       valid_w [2];
    logic [7:0] pend_w  [2];
    logic [3:0] cnt_w   [2];
    logic       ovf_w   [2];
    logic       dbg_w   [2];

    int n_cmp;
    int n_err;

    // Behavioural model state, index 0: LOW_FIRST=1, index 1: LOW_FIRST=0.
    logic [7:0] m_pend  [2];
    int         m_cur   [2];
    bit         m_offer [2];
    bit         m_ovf   [2];

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    event_encoder_8x3 #(.LOW_FIRST(1'b1)) u_lo (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .ready     (ready),
        .y         (y_w[0]),
        .valid     (valid_w[0]),
        .pend      (pend_w[0]),
        .cnt       (cnt_w[0]),
        .ovf       (ovf_w[0]),
        .dbg_state (dbg_w[0])
    );

    event_encoder_8x3 #(.LOW_FIRST(1'b0)) u_hi (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .ready     (ready),
        .y         (y_w[1]),
        .valid     (valid_w[1]),
        .pend      (pend_w[1]),
        .cnt       (cnt_w[1]),
        .ovf       (ovf_w[1]),
        .dbg_state (dbg_w[1])
    );

    // ---------------- model ----------------
    function automatic int prio(input logic [7:0] v, input bit low_first);
        if (low_first) begin
            for (int k = 0; k < 8; k++) if (v[k]) return k;
        end else begin
            for (int k = 7; k >= 0; k--) if (v[k]) return k;
        end
        return 0;
    endfunction

    function automatic int ones(input logic [7:0] v);
        int c;
        c = 0;
        for (int k = 0; k < 8; k++) c += int'(v[k]);
        return c;
    endfunction

    task automatic model_step(input logic [7:0] r, input logic rd, input logic rs);
        logic [7:0] clr;
        logic [7:0] rest;
        logic [7:0] nxt;
        for (int i = 0; i < 2; i++) begin
            if (rs) begin
                m_pend[i]  = 8'h00;
                m_cur[i]   = 0;
                m_offer[i] = 1'b0;
                m_ovf[i]   = 1'b0;
            end else begin
                clr = (m_offer[i] && rd) ? (8'h01 << m_cur[i]) : 8'h00;
                if ((r & m_pend[i] & ~clr) != 8'h00) m_ovf[i] = 1'b1;
                nxt = (m_pend[i] & ~clr) | r;
                if (!m_offer[i]) begin
                    if (m_pend[i] != 8'h00) begin
                        m_cur[i]   = prio(m_pend[i], i == 0);
                        m_offer[i] = 1'b1;
                    end
                end else if (rd) begin
                    rest = m_pend[i] & ~(8'h01 << m_cur[i]);
                    if (rest != 8'h00) m_cur[i] = prio(rest, i == 0);
                    else               m_offer[i] = 1'b0;
                end
                m_pend[i] = nxt;
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_model();
        logic [7:0] exp_y;
        for (int i = 0; i < 2; i++) begin
            exp_y = m_offer[i] ? 8'(m_cur[i]) : 8'h00;
            chk($sformatf("model_y[%0d]", i),     8'(y_w[i]),     exp_y);
            chk($sformatf("model_valid[%0d]", i), 8'(valid_w[i]), 8'(m_offer[i]));
            chk($sformatf("model_pend[%0d]", i),  pend_w[i],      m_pend[i]);
            chk($sformatf("model_cnt[%0d]", i),   8'(cnt_w[i]),   8'(ones(m_pend[i])));
            chk($sformatf("model_ovf[%0d]", i),   8'(ovf_w[i]),   8'(m_ovf[i]));
            chk($sformatf("model_dbg[%0d]", i),   8'(dbg_w[i]),   8'(m_offer[i]));
        end
    endtask

    // ---------------- driver ----------------
    // Inputs change on the falling edge, are sampled on the rising edge,
    // and outputs are compared on the next falling edge.
    task automatic cycle(input logic [7:0] r, input logic rd, input logic rs);
        req   = r;
        ready = rd;
        rst   = rs;
        @(posedge clk);
        model_step(r, rd, rs);
        @(negedge clk);
        check_model();
    endtask

    task automatic do_reset();
        cycle(8'h00, 1'b0, 1'b1);
        cycle(8'h00, 1'b0, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] r;
        n_cmp = 0;
        n_err = 0;
        req   = 8'h00;
        ready = 1'b0;
        rst   = 1'b1;
        for (int i = 0; i < 2; i++) begin
            m_pend[i] = 8'h00; m_cur[i] = 0; m_offer[i] = 1'b0; m_ovf[i] = 1'b0;
        end

        // Reset state
        do_reset();
        chk("rst_y",     8'(y_w[0]),     8'h00);
        chk("rst_valid", 8'(valid_w[0]), 8'h00);
        chk("rst_cnt",   8'(cnt_w[0]),   8'h00);
        chk("rst_pend",  pend_w[0],      8'h00);
        chk("rst_ovf",   8'(ovf_w[0]),   8'h00);

        // Single event: pend after the req edge, offer one edge later
        cycle(8'h08, 1'b1, 1'b0);
        chk("single_pend",   pend_w[0],      8'h08);
        chk("single_valid0", 8'(valid_w[0]), 8'h00);
        cycle(8'h00, 1'b1, 1'b0);
        chk("single_valid1", 8'(valid_w[0]), 8'h01);
        chk("single_y",      8'(y_w[0]),     8'h03);
        cycle(8'h00, 1'b1, 1'b0);
        chk("single_done",   8'(valid_w[0]), 8'h00);
        chk("single_cnt",    8'(cnt_w[0]),   8'h00);

        // Burst drain A5: low-first 0,2,5,7 and high-first 7,5,2,0
        cycle(8'hA5, 1'b1, 1'b0);
        chk("burst_cnt", 8'(cnt_w[0]), 8'h04);
        cycle(8'h00, 1'b1, 1'b0);
        chk("burst_lo_0", 8'(y_w[0]), 8'h00);
        chk("burst_hi_0", 8'(y_w[1]), 8'h07);
        cycle(8'h00, 1'b1, 1'b0);
        chk("burst_lo_1", 8'(y_w[0]), 8'h02);
        chk("burst_hi_1", 8'(y_w[1]), 8'h05);
        cycle(8'h00, 1'b1, 1'b0);
        chk("burst_lo_2", 8'(y_w[0]), 8'h05);
        cycle(8'h00, 1'b1, 1'b0);
        chk("burst_lo_3", 8'(y_w[0]), 8'h07);
        chk("burst_valid", 8'(valid_w[0]), 8'h01);
        cycle(8'h00, 1'b1, 1'b0);
        chk("burst_end_valid", 8'(valid_w[0]), 8'h00);
        chk("burst_end_ovf",   8'(ovf_w[0]),   8'h00);

        // Stall stability: y=5 held through a higher-priority req
        cycle(8'h20, 1'b0, 1'b0);
        cycle(8'h00, 1'b0, 1'b0);
        chk("stall_y0", 8'(y_w[0]), 8'h05);
        cycle(8'h01, 1'b0, 1'b0);
        chk("stall_y1", 8'(y_w[0]), 8'h05);
        cycle(8'h00, 1'b0, 1'b0);
        chk("stall_y2", 8'(y_w[0]), 8'h05);
        cycle(8'h00, 1'b1, 1'b0);
        chk("stall_next_y", 8'(y_w[0]),     8'h00);
        chk("stall_next_v", 8'(valid_w[0]), 8'h01);
        chk("stall_pend",   pend_w[0],      8'h01);
        cycle(8'h00, 1'b1, 1'b0);

        // Coincidence: req[4] on the edge accepting y=4
        do_reset();
        cycle(8'h10, 1'b0, 1'b0);
        cycle(8'h00, 1'b0, 1'b0);
        chk("coin_y", 8'(y_w[0]), 8'h04);
        cycle(8'h10, 1'b1, 1'b0);
        chk("coin_pend",  pend_w[0],      8'h10);
        chk("coin_ovf",   8'(ovf_w[0]),   8'h00);
        chk("coin_valid", 8'(valid_w[0]), 8'h00);
        cycle(8'h00, 1'b0, 1'b0);
        chk("coin_reoffer", 8'(y_w[0]), 8'h04);
        cycle(8'h00, 1'b1, 1'b0);

        // Overflow: req[2] while pend[2]=1 and no accept; sticky
        cycle(8'h04, 1'b0, 1'b0);
        cycle(8'h00, 1'b0, 1'b0);
        cycle(8'h04, 1'b0, 1'b0);
        chk("ovf_set", 8'(ovf_w[0]), 8'h01);
        cycle(8'h00, 1'b1, 1'b0);
        chk("ovf_sticky", 8'(ovf_w[0]), 8'h01);

        // Full vector, then reset mid-offer with req/ready active
        do_reset();
        cycle(8'hFF, 1'b0, 1'b0);
        chk("full_cnt", 8'(cnt_w[0]), 8'h08);
        cycle(8'h00, 1'b0, 1'b0);
        chk("full_lo_y", 8'(y_w[0]), 8'h00);
        chk("full_hi_y", 8'(y_w[1]), 8'h07);
        cycle(8'hFF, 1'b0, 1'b0);
        chk("full_ovf", 8'(ovf_w[0]), 8'h01);
        cycle(8'hFF, 1'b1, 1'b1);
        chk("midrst_valid", 8'(valid_w[0]), 8'h00);
        chk("midrst_pend",  pend_w[0],      8'h00);
        chk("midrst_cnt",   8'(cnt_w[0]),   8'h00);
        chk("midrst_ovf",   8'(ovf_w[0]),   8'h00);

        // LOW_FIRST=0 with 81: 7 then 0
        cycle(8'h81, 1'b1, 1'b0);
        cycle(8'h00, 1'b1, 1'b0);
        chk("hi81_y0", 8'(y_w[1]), 8'h07);
        chk("lo81_y0", 8'(y_w[0]), 8'h00);
        cycle(8'h00, 1'b1, 1'b0);
        chk("hi81_y1", 8'(y_w[1]), 8'h00);
        chk("lo81_y1", 8'(y_w[0]), 8'h07);
        cycle(8'h00, 1'b1, 1'b0);

        // Randomized traffic with occasional resets
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 3) == 0) r = 8'($urandom) & 8'($urandom);
            else                           r = 8'h00;
            cycle(r, $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
